axil_master_arbiter: RTL

//  Round-robin arbiter that shares one AXI4-Lite master port between NREQ simple

---
 rtl/axil_master_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NREQ single-beat requesters.
// Optional watchdog abort when AXIL_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module axil_master_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0]  req_wstrb,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    req_done,
    output logic [31:0]        req_rdata,
    output logic               req_err,
    output logic [31:0]        M_AXI_AWADDR,
    output logic               M_AXI_AWVALID,
    input  logic               M_AXI_AWREADY,
    output logic [31:0]        M_AXI_WDATA,
    output logic [3:0]         M_AXI_WSTRB,
    output logic               M_AXI_WVALID,
    input  logic               M_AXI_WREADY,
    input  logic [1:0]         M_AXI_BRESP,
    input  logic               M_AXI_BVALID,
    output logic               M_AXI_BREADY,
    output logic [31:0]        M_AXI_ARADDR,
    output logic               M_AXI_ARVALID,
    input  logic               M_AXI_ARREADY,
    input  logic [31:0]        M_AXI_RDATA,
    input  logic [1:0]         M_AXI_RRESP,
    input  logic               M_AXI_RVALID,
    output logic               M_AXI_RREADY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RDATA,
        DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_found;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;

`ifdef AXIL_TIMEOUT_EN
    logic [15:0]     tmo_cnt;
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
`endif

    logic unused_resp;
    assign unused_resp = ^{M_AXI_BRESP[0], M_AXI_RRESP[0]};

    // Address/data come straight from the latched request, so they stay stable under VALID.
    assign M_AXI_AWADDR = addr_q;
    assign M_AXI_ARADDR = addr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;

    // Descending scan with last-hit-wins picks the closest requester after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= IW'(NREQ - 1);
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            req_ready     <= '0;
            req_done      <= '0;
            req_rdata     <= '0;
            req_err       <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            req_ready <= '0;
            req_done  <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        rr_ptr             <= gnt_idx;
                        addr_q             <= req_addr[32*gnt_idx +: 32];
                        wdata_q            <= req_wdata[32*gnt_idx +: 32];
                        wstrb_q            <= req_wstrb[4*gnt_idx +: 4];
                        req_ready[gnt_idx] <= 1'b1;
                        if (req_write[gnt_idx]) begin
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WADDR;
                        end else begin
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) &&
                        (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        req_err          <= M_AXI_BRESP[1];
                        M_AXI_BREADY     <= 1'b0;
                        req_done[rr_ptr] <= 1'b1;
                        state            <= DONE;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        req_rdata        <= M_AXI_RDATA;
                        req_err          <= M_AXI_RRESP[1];
                        M_AXI_RREADY     <= 1'b0;
                        req_done[rr_ptr] <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef AXIL_TIMEOUT_EN
            // Debug abort: abandon the slave handshake and report an error.
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else if (state != DONE) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    M_AXI_AWVALID    <= 1'b0;
                    M_AXI_WVALID     <= 1'b0;
                    M_AXI_BREADY     <= 1'b0;
                    M_AXI_ARVALID    <= 1'b0;
                    M_AXI_RREADY     <= 1'b0;
                    req_err          <= 1'b1;
                    req_rdata        <= '0;
                    req_done         <= '0;
                    req_done[rr_ptr] <= 1'b1;
                    state            <= DONE;
                end
            end
`endif
        end
    end

endmodule
